xs3_to_bcd_fsm: RTL and testbench

Serial Excess-3 to BCD decoder. It is the receive-side counterpart of the serial BCD-to-XS3 encoder FSM.
- Collects one 4-bit XS-3 digit from a 1-bit serial input.
- Subtracts 3 in a single compute cycle.
- Shifts the 4-bit BCD result out serially with a valid strobe.
- Sits downstream of the encoder on the same 1-bit serial link; internal registers are exposed for bench/debug probing.

---
 rtl/xs3_to_bcd_fsm.sv | 115 +++++++++++
 tb/tb_xs3_to_bcd_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/xs3_to_bcd_fsm.sv
// Serial Excess-3 to BCD decoder: collect 4 bits, subtract 3, shift 4 bits out.
// Define XS3_ERR_CHECK_EN to flag invalid XS-3 codes and send zeros for them.
module xs3_to_bcd_fsm #(
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    input  logic       in_valid,
    output logic       out,
    output logic       out_valid,
    output logic       busy,
    output logic       err,
    output logic [3:0] s_xs3_in,
    output logic [3:0] s_bcd_out
);
    typedef enum logic [1:0] {
        S_RECV = 2'd0,
        S_CALC = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_cnt;
    logic [1:0] w_idx;
    logic [3:0] r_xs3;
    logic [3:0] r_bcd;
    logic [3:0] w_bcd;
    logic       r_err;
    logic       w_bad;

    // For a 2-bit counter, 3-cnt is simply the bitwise inverse.
    assign w_idx = (LSB_FIRST != 0) ? r_cnt : ~r_cnt;

`ifdef XS3_ERR_CHECK_EN
    assign w_bad = (r_xs3 < 4'd3) || (r_xs3 > 4'd12);
`else
    assign w_bad = 1'b0;
`endif

    assign w_bcd = w_bad ? 4'd0 : r_xs3 - 4'd3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RECV;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_RECV: begin
                if (in_valid && (r_cnt == 2'd3)) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: w_next = S_SEND;
            S_SEND: begin
                if (r_cnt == 2'd3) begin
                    w_next = S_RECV;
                end
            end
            default: w_next = S_RECV;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 2'd0;
            r_xs3 <= 4'd0;
            r_bcd <= 4'd0;
            r_err <= 1'b0;
        end else begin
            unique case (r_state)
                S_RECV: begin
                    if (in_valid) begin
                        r_xs3[w_idx] <= in;
                        r_cnt        <= r_cnt + 2'd1;
                    end
                end
                S_CALC: begin
                    r_bcd <= w_bcd;
                    r_err <= w_bad;
                    r_cnt <= 2'd0;
                end
                S_SEND: r_cnt <= r_cnt + 2'd1;
                default: r_cnt <= 2'd0;
            endcase
        end
    end

    // Outputs decode registered state only, so `in` cannot glitch them.
    always_comb begin
        out       = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (r_state)
            S_CALC: busy = 1'b1;
            S_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out       = r_bcd[w_idx];
            end
            default: ;
        endcase
    end

    assign err       = r_err;
    assign s_xs3_in  = r_xs3;
    assign s_bcd_out = r_bcd;

endmodule

// File: tb/tb_xs3_to_bcd_fsm.sv
// Bench for xs3_to_bcd_fsm: LSB-first and MSB-first instances share one serial
// stream; a vector table, hand sequences and random digits check both.
module tb_xs3_to_bcd_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in = 1'b0;
    logic       in_valid = 1'b0;

    logic       out_l, ov_l, busy_l, err_l;
    logic [3:0] xs_l, bcd_l;
    logic       out_m, ov_m, busy_m, err_m;
    logic [3:0] xs_m, bcd_m;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xs3_to_bcd_fsm #(.LSB_FIRST(1)) u_lsb (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .out(out_l), .out_valid(ov_l), .busy(busy_l), .err(err_l),
        .s_xs3_in(xs_l), .s_bcd_out(bcd_l)
    );

    xs3_to_bcd_fsm #(.LSB_FIRST(0)) u_msb (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .out(out_m), .out_valid(ov_m), .busy(busy_m), .err(err_m),
        .s_xs3_in(xs_m), .s_bcd_out(bcd_m)
    );

    typedef struct {
        logic [3:0] xs3;
        logic [3:0] bcd_plain;
        logic [3:0] bcd_chk;
        logic       err_chk;
        int         gap;
        bit         noise;
    } vec_t;

    vec_t vecs[9];

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    // Reference: decimal value of an XS-3 code is code minus three.
    function automatic void model(input logic [3:0] x,
                                  output logic [3:0] b, output logic e);
        int v;
        v = int'(x) - 3;
        if (v < 0) v += 16;
        b = 4'(v);
        e = 1'b0;
`ifdef XS3_ERR_CHECK_EN
        if (int'(x) < 3 || int'(x) > 12) begin
            e = 1'b1;
            b = 4'd0;
        end
`endif
    endfunction

    // Serial bit i of the stream is x[i]; returns #1 after the 4th sample edge.
    task automatic feed(input logic [3:0] x, input int gap);
        for (int i = 0; i < 4; i++) begin
            in = x[i];
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (i == 1) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    in = ~in;
                    @(posedge clk); #1;
                end
            end
        end
        in_valid = 1'b0;
        in = 1'b0;
    endtask

    task automatic drain(input logic [3:0] x, input logic [3:0] be,
                         input logic ee, input bit noise);
        logic [3:0] bm;
        logic       em;
        model(rev4(x), bm, em);
        chk1("calc_busy_l", busy_l, 1'b1);
        chk1("calc_ov_l", ov_l, 1'b0);
        chk1("calc_busy_m", busy_m, 1'b1);
        chk1("calc_ov_m", ov_m, 1'b0);
        if (noise) begin
            in_valid = 1'($urandom);
            in = 1'($urandom);
        end
        @(posedge clk); #1;
        chk4("xs3_l", xs_l, x);
        chk4("bcd_l", bcd_l, be);
        chk1("err_l", err_l, ee);
        chk4("xs3_m", xs_m, rev4(x));
        chk4("bcd_m", bcd_m, bm);
        chk1("err_m", err_m, em);
        for (int k = 0; k < 4; k++) begin
            chk1("out_l", out_l, be[k]);
            chk1("ov_l", ov_l, 1'b1);
            chk1("busy_l", busy_l, 1'b1);
            chk1("out_m", out_m, bm[3-k]);
            chk1("ov_m", ov_m, 1'b1);
            chk1("busy_m", busy_m, 1'b1);
            if (noise) begin
                in_valid = 1'($urandom);
                in = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in = 1'b0;
        chk1("idle_ov_l", ov_l, 1'b0);
        chk1("idle_busy_l", busy_l, 1'b0);
        chk1("idle_out_l", out_l, 1'b0);
        chk1("idle_ov_m", ov_m, 1'b0);
        chk1("idle_busy_m", busy_m, 1'b0);
        chk1("hold_bcd_l", bcd_l, be);
        chk1("hold_err_l", err_l, ee);
    endtask

    task automatic chk_reset_state(input string nm);
        chk1({nm, "_out_l"}, out_l, 1'b0);
        chk1({nm, "_ov_l"}, ov_l, 1'b0);
        chk1({nm, "_busy_l"}, busy_l, 1'b0);
        chk1({nm, "_err_l"}, err_l, 1'b0);
        chk4({nm, "_xs3_l"}, xs_l, 4'd0);
        chk4({nm, "_bcd_l"}, bcd_l, 4'd0);
        chk1({nm, "_ov_m"}, ov_m, 1'b0);
        chk1({nm, "_busy_m"}, busy_m, 1'b0);
        chk4({nm, "_bcd_m"}, bcd_m, 4'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] x, b;
        logic       e;

        vecs[0] = '{4'b0100, 4'b0001, 4'b0001, 1'b0, 0, 1'b0};
        vecs[1] = '{4'b1100, 4'b1001, 4'b1001, 1'b0, 0, 1'b0};
        vecs[2] = '{4'b0011, 4'b0000, 4'b0000, 1'b0, 0, 1'b0};
        vecs[3] = '{4'b0111, 4'b0100, 4'b0100, 1'b0, 3, 1'b0};
        vecs[4] = '{4'b0000, 4'b1101, 4'b0000, 1'b1, 0, 1'b0};
        vecs[5] = '{4'b0101, 4'b0010, 4'b0010, 1'b0, 1, 1'b0};
        vecs[6] = '{4'b1111, 4'b1100, 4'b0000, 1'b1, 0, 1'b1};
        vecs[7] = '{4'b0010, 4'b1111, 4'b0000, 1'b1, 2, 1'b0};
        vecs[8] = '{4'b1101, 4'b1010, 4'b0000, 1'b1, 0, 1'b1};

        #12;
        chk_reset_state("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        foreach (vecs[i]) begin
            feed(vecs[i].xs3, vecs[i].gap);
`ifdef XS3_ERR_CHECK_EN
            drain(vecs[i].xs3, vecs[i].bcd_chk, vecs[i].err_chk, vecs[i].noise);
`else
            drain(vecs[i].xs3, vecs[i].bcd_plain, 1'b0, vecs[i].noise);
`endif
        end

        // Reset during the second output bit of digit 1001.
        feed(4'b1100, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk1("pre_rst_ov_l", ov_l, 1'b1);
        rst = 1'b0;
        #1;
        chk_reset_state("async_rst");
        @(posedge clk); #1;
        chk_reset_state("held_rst");
        rst = 1'b1;
        feed(4'b0101, 0);
        drain(4'b0101, 4'b0010, 1'b0, 1'b0);

        // Reset with a partially received digit; the fragment must be discarded.
        in = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_reset_state("recv_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        feed(4'b1000, 0);
        model(4'b1000, b, e);
        drain(4'b1000, b, e, 1'b0);

        for (int n = 0; n < 40; n++) begin
            x = 4'($urandom);
            model(x, b, e);
            feed(x, int'($urandom_range(3, 0)));
            drain(x, b, e, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
